// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared opcodes, FSM state encoding, ALUOp codes and the
//               control-bundle type for the multi-cycle control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Opcode map (instruction[15:13]); 011 and 110 are unassigned.
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_BEQ   = 3'b010;
    localparam logic [2:0] OP_LW    = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // ALU operation select presented to the datapath.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Sequencer states, binary encoded in pipeline order.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    // Full control bundle driven towards the datapath.
    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       ir_write;
    } ctrl_t;

    // True for every assigned opcode, HALT included.
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_ADDI, OP_BEQ, OP_LW, OP_SW, OP_HALT: legal = 1'b1;
            default:                                          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True for instructions whose second ALU operand is the immediate.
    function automatic logic op_uses_imm(input logic [2:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Purely combinational decode of (state, opcode) into the
//               datapath control bundle, PC write and IR write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  state_t     i_state,
    input  logic [2:0] i_op,
    input  logic       i_stall,
    output ctrl_t      o_ctrl
);

    // Moore decode; i_op is the live opcode in DECODE and the latched one
    // afterwards. i_stall only gates the SW PC update so a stalled store
    // never advances the PC.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.ir_write = 1'b1;
            end
            S_DECODE: begin
                // An illegal opcode retires here as a NOP unless it traps.
                if (!op_is_legal(i_op) && !ILLEGAL_TRAP) begin
                    o_ctrl.pc_write = 1'b1;
                end
            end
            S_EXEC, S_MEM, S_WB: begin
                // ALU controls stay stable for the whole execution phase.
                o_ctrl.alu_src = op_uses_imm(i_op);
                case (i_op)
                    OP_RTYPE: o_ctrl.alu_op = ALUOP_FUNCT;
                    OP_BEQ:   o_ctrl.alu_op = ALUOP_SUB;
                    default:  o_ctrl.alu_op = ALUOP_ADD;
                endcase

                if (i_state == S_EXEC) begin
                    if (i_op == OP_BEQ) begin
                        o_ctrl.branch   = 1'b1;
                        o_ctrl.pc_write = 1'b1;
                    end
                end else if (i_state == S_MEM) begin
                    if (i_op == OP_LW) begin
                        o_ctrl.mem_read = 1'b1;
                    end else if (i_op == OP_SW) begin
                        o_ctrl.mem_write = 1'b1;
                        o_ctrl.pc_write  = !i_stall;
                    end
                end else begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.pc_write   = 1'b1;
                    o_ctrl.reg_dst    = (i_op == OP_RTYPE);
                    o_ctrl.mem_to_reg = (i_op == OP_LW);
                end
            end
            default: begin
                // HALTED and unused encodings drive no strobes.
                o_ctrl = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle control sequencer for the 16-bit datapath.
//               Holds the state register, the latched opcode, the
//               next-state logic and the retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH  = 16,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [2:0]             opcode,
    input  logic                   Stall,
    output logic                   RegDst,
    output logic                   Branch,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   RegWrite,
    output logic                   MemToReg,
    output logic                   ALUSrc,
    output logic [1:0]             ALUOp,
    output logic                   PCWrite,
    output logic                   IRWrite,
    output logic                   Halted,
    output logic [COUNT_WIDTH-1:0] RetireCount
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [2:0]             r_op_q;
    logic [2:0]             w_op_sel;
    logic [COUNT_WIDTH-1:0] r_retire;
    ctrl_t                  w_ctrl;

    // In DECODE the opcode has not been latched yet, so decode it live.
    assign w_op_sel = (r_state == S_DECODE) ? opcode : r_op_q;

    ctrl_decode #(
        .ILLEGAL_TRAP (ILLEGAL_TRAP)
    ) u_ctrl_decode (
        .i_state (r_state),
        .i_op    (w_op_sel),
        .i_stall (Stall),
        .o_ctrl  (w_ctrl)
    );

    // Next-state selection from the current state and the opcode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    w_next_state = S_HALTED;
                end else if (!op_is_legal(opcode)) begin
                    w_next_state = ILLEGAL_TRAP ? S_HALTED : S_FETCH;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_op_q)
                    OP_BEQ:        w_next_state = S_FETCH;
                    OP_LW, OP_SW:  w_next_state = S_MEM;
                    default:       w_next_state = S_WB;
                endcase
            end
            S_MEM: begin
                // Memory wait-states hold the FSM here.
                if (!Stall) begin
                    w_next_state = (r_op_q == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                w_next_state = S_FETCH;
            end
            S_HALTED: begin
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode latch, updated only on the DECODE edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_op_q <= OP_RTYPE;
        end else if (r_state == S_DECODE) begin
            r_op_q <= opcode;
        end
    end

    // Retired-instruction counter, one count per PC update, wrapping.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_retire <= '0;
        end else if (w_ctrl.pc_write) begin
            r_retire <= r_retire + COUNT_WIDTH'(1);
        end
    end

    assign RegDst      = w_ctrl.reg_dst;
    assign Branch      = w_ctrl.branch;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign RegWrite    = w_ctrl.reg_write;
    assign MemToReg    = w_ctrl.mem_to_reg;
    assign ALUSrc      = w_ctrl.alu_src;
    assign ALUOp       = w_ctrl.alu_op;
    assign PCWrite     = w_ctrl.pc_write;
    assign IRWrite     = w_ctrl.ir_write;
    assign Halted      = (r_state == S_HALTED);
    assign RetireCount = r_retire;

endmodule
`default_nettype wire
